// File: rtl/launcher_pkg.sv
// Shared types and the operand LFSR step function for prog_launcher.
package launcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        CORE_RST,
        REQ,
        RUN,
        READBACK,
        REPORT
    } state_t;

    // Feedback taps q7, q5, q4, q3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/prog_launcher_lfsr8.sv
// 8-bit Fibonacci LFSR that produces the operand bytes written during preload.
module lfsr8
    import launcher_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    // Load takes priority so a fresh run always starts from the seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 8'h01;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/prog_launcher.sv
// Drives one full core run: preload, core reset/req, run timing, readback checksum.
// Optional watchdog on the RUN phase is enabled with `define PROG_LAUNCHER_WATCHDOG_EN.
module prog_launcher
    import launcher_pkg::*;
#(
    parameter int           LEN     = 32,
    parameter logic [7:0]   BASE    = 8'h00,
    parameter int           RLEN    = 32,
    parameter logic [7:0]   RBASE   = 8'h40,
    parameter logic [7:0]   SEED    = 8'hA5,
    parameter int           RST_CYC = 2,
    parameter int           CW      = 16,
    parameter int           TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycles,
    output logic [15:0]   checksum,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          mem_own,
    output logic          mem_wr_en,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_wr_dat,
    input  logic [7:0]    mem_rd_dat
);

`ifdef PROG_LAUNCHER_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam logic [7:0]    SEED_FIX  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0]   LEN_LAST  = 16'(LEN - 1);
    localparam logic [15:0]   RLEN_LAST = 16'(RLEN - 1);
    localparam logic [15:0]   RST_LAST  = 16'(RST_CYC - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_CYC    = CW'(TIMEOUT);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  lfsr_q;
    logic        accept;

    assign accept = (state == IDLE) && start;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .seed  (SEED_FIX),
        .step  (state == PRELOAD),
        .q     (lfsr_q)
    );

    // All outputs are registered and set up on the edge that enters the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            timeout    <= 1'b0;
            cycles     <= '0;
            checksum   <= '0;
            core_reset <= 1'b1;
            core_req   <= 1'b0;
            mem_own    <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wr_dat <= '0;
        end else begin
            core_req <= 1'b0;
            finished <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cycles   <= '0;
                        checksum <= '0;
                        timeout  <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        if (LEN != 0) begin
                            state      <= PRELOAD;
                            mem_own    <= 1'b1;
                            mem_wr_en  <= 1'b1;
                            mem_addr   <= BASE;
                            mem_wr_dat <= SEED_FIX;
                        end else begin
                            state <= CORE_RST;
                        end
                    end
                end
                PRELOAD: begin
                    if (cnt == LEN_LAST) begin
                        state      <= CORE_RST;
                        cnt        <= '0;
                        mem_own    <= 1'b0;
                        mem_wr_en  <= 1'b0;
                        mem_addr   <= '0;
                        mem_wr_dat <= '0;
                    end else begin
                        cnt        <= cnt + 16'd1;
                        mem_addr   <= mem_addr + 8'd1;
                        mem_wr_dat <= lfsr_next(lfsr_q);
                    end
                end
                CORE_RST: begin
                    if (cnt == RST_LAST) begin
                        state      <= REQ;
                        core_reset <= 1'b0;
                        core_req   <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                REQ: begin
                    state <= RUN;
                end
                // cycles doubles as the RUN index k until it saturates; done beats the watchdog.
                RUN: begin
                    if (core_done) begin
                        core_reset <= 1'b1;
                        cnt        <= '0;
                        if (RLEN != 0) begin
                            state    <= READBACK;
                            mem_own  <= 1'b1;
                            mem_addr <= RBASE;
                        end else begin
                            state    <= REPORT;
                            finished <= 1'b1;
                        end
                    end else if (WD_EN && cycles == TO_LAST) begin
                        core_reset <= 1'b1;
                        state      <= REPORT;
                        finished   <= 1'b1;
                        timeout    <= 1'b1;
                        cycles     <= TO_CYC;
                    end else if (cycles != '1) begin
                        cycles <= cycles + 1'b1;
                    end
                end
                READBACK: begin
                    checksum <= checksum + {8'h00, mem_rd_dat};
                    if (cnt == RLEN_LAST) begin
                        state    <= REPORT;
                        finished <= 1'b1;
                        mem_own  <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        cnt      <= cnt + 16'd1;
                        mem_addr <= mem_addr + 8'd1;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher with a simple core model and an address-echo memory.
module tb_prog_launcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, finished, timeout;
    logic [15:0] cycles;
    logic [15:0] checksum;
    logic        core_reset, core_req, core_done;
    logic        mem_own, mem_wr_en;
    logic [7:0]  mem_addr, mem_wr_dat, mem_rd_dat;

    int checks = 0;
    int errors = 0;
    int run_k = 0;
    int done_at = -1;
    int finished_count = 0;

    always #5 clk = ~clk;

    prog_launcher #(
        .LEN(4), .BASE(8'h10), .RLEN(4), .RBASE(8'h40), .SEED(8'hA5),
        .RST_CYC(2), .CW(16), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .finished(finished),
        .timeout(timeout), .cycles(cycles), .checksum(checksum),
        .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
        .mem_own(mem_own), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_dat(mem_wr_dat), .mem_rd_dat(mem_rd_dat)
    );

    assign mem_rd_dat = mem_addr;
    assign core_done  = !core_reset && !core_req && (run_k == done_at);

    always @(posedge clk) begin
        if (core_req) run_k <= 0;
        else if (!core_reset) run_k <= run_k + 1;
    end

    always @(negedge clk) if (finished) finished_count = finished_count + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset got %b want 1", core_reset); end
        checks++; if ({core_req, mem_own, mem_wr_en, finished, timeout} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {core_req, mem_own, mem_wr_en, finished, timeout}); end
        checks++; if ({cycles, checksum, mem_addr, mem_wr_dat} !== 48'h0) begin
            errors++; $display("FAIL reset_values got %h want 0", {cycles, checksum, mem_addr, mem_wr_dat}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_preload();
        logic [7:0] exp_dat [4] = '{8'hA5, 8'h4A, 8'h95, 8'h2A};
        int n = 0;
        done_at = 9;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_wr_en !== 1'b1 || mem_own !== 1'b1) begin
                errors++; $display("FAIL preload_en[%0d] got wr_en=%b own=%b want 1 1", i, mem_wr_en, mem_own); end
            checks++; if (mem_addr !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL preload_addr[%0d] got %h want %h", i, mem_addr, 8'h10 + 8'(i)); end
            checks++; if (mem_wr_dat !== exp_dat[i]) begin
                errors++; $display("FAIL preload_dat[%0d] got %h want %h", i, mem_wr_dat, exp_dat[i]); end
            tick();
        end
        checks++; if (mem_wr_en !== 1'b0 || mem_addr !== 8'h00 || mem_wr_dat !== 8'h00) begin
            errors++; $display("FAIL preload_end got en=%b addr=%h dat=%h want 0 00 00", mem_wr_en, mem_addr, mem_wr_dat); end
        while (core_reset && n < 20) begin
            n++;
            tick();
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL core_rst_len got %0d want 2", n); end
        checks++; if (core_req !== 1'b1) begin errors++; $display("FAIL req_pulse got %b want 1", core_req); end
    endtask

    task automatic test_run_readback();
        int k = 0;
        int fc;
        tick();
        checks++; if (core_req !== 1'b0 || core_reset !== 1'b0) begin
            errors++; $display("FAIL run_entry got req=%b crst=%b want 0 0", core_req, core_reset); end
        while (!core_done && k < 50) begin
            tick();
            k++;
        end
        checks++; if (k !== 9) begin errors++; $display("FAIL done_cycle got %0d want 9", k); end
        checks++; if (cycles !== 16'd9) begin errors++; $display("FAIL run_cycles got %0d want 9", cycles); end
        tick();
        checks++; if (mem_own !== 1'b1 || core_reset !== 1'b1) begin
            errors++; $display("FAIL readback_entry got own=%b crst=%b want 1 1", mem_own, core_reset); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_addr !== 8'h40 + 8'(i) || mem_wr_en !== 1'b0) begin
                errors++; $display("FAIL readback_addr[%0d] got %h en=%b want %h 0", i, mem_addr, mem_wr_en, 8'h40 + 8'(i)); end
            tick();
        end
        fc = finished_count;
        checks++; if (finished !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL report got fin=%b busy=%b want 1 1", finished, busy); end
        checks++; if (checksum !== 16'h0106) begin errors++; $display("FAIL checksum got %h want 0106", checksum); end
        tick();
        checks++; if (busy !== 1'b0 || finished !== 1'b0) begin
            errors++; $display("FAIL idle_after got busy=%b fin=%b want 0 0", busy, finished); end
        checks++; if (checksum !== 16'h0106 || cycles !== 16'd9) begin
            errors++; $display("FAIL held_results got cs=%h cyc=%0d want 0106 9", checksum, cycles); end
        checks++; if (finished_count !== fc + 1) begin
            errors++; $display("FAIL finished_once got %0d want %0d", finished_count, fc + 1); end
    endtask

    task automatic test_watchdog();
        int n = 0;
        int fc = finished_count;
        done_at = -1;
        pulse_start();
`ifdef PROG_LAUNCHER_WATCHDOG_EN
        while (!finished && n < 200) begin
            tick();
            n++;
        end
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL wd_finish got %b want 1", finished); end
        checks++; if (timeout !== 1'b1 || cycles !== 16'd64 || checksum !== 16'h0000) begin
            errors++; $display("FAIL wd_result got to=%b cyc=%0d cs=%h want 1 64 0000", timeout, cycles, checksum); end
        tick();
        checks++; if (busy !== 1'b0 || timeout !== 1'b1) begin
            errors++; $display("FAIL wd_hold got busy=%b to=%b want 0 1", busy, timeout); end
`else
        repeat (10050) tick();
        checks++; if (busy !== 1'b1 || timeout !== 1'b0 || finished_count !== fc) begin
            errors++; $display("FAIL no_wd_wait got busy=%b to=%b fin=%0d want 1 0 %0d", busy, timeout, finished_count, fc); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif
        n = fc;
    endtask

    task automatic test_mid_run_reset();
        int n = 0;
        done_at = -1;
        pulse_start();
        checks++; if (timeout !== 1'b0 || cycles !== 16'd0 || checksum !== 16'h0000) begin
            errors++; $display("FAIL start_clears got to=%b cyc=%0d cs=%h want 0 0 0000", timeout, cycles, checksum); end
        while (!core_req && n < 50) begin
            tick();
            n++;
        end
        checks++; if (core_req !== 1'b1) begin errors++; $display("FAIL mid_req got %b want 1", core_req); end
        repeat (6) tick();
        checks++; if (cycles !== 16'd5) begin errors++; $display("FAIL mid_k5 got %0d want 5", cycles); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || core_reset !== 1'b1 || cycles !== 16'd0 || mem_own !== 1'b0) begin
            errors++; $display("FAIL mid_reset got busy=%b crst=%b cyc=%0d own=%b want 0 1 0 0", busy, core_reset, cycles, mem_own); end
        tick();
        reset = 1'b0;
        tick();
        done_at = 3;
        pulse_start();
        n = 0;
        while (!finished && n < 200) begin
            tick();
            n++;
        end
        checks++; if (finished !== 1'b1 || cycles !== 16'd3 || checksum !== 16'h0106 || timeout !== 1'b0) begin
            errors++; $display("FAIL rerun got fin=%b cyc=%0d cs=%h to=%b want 1 3 0106 0", finished, cycles, checksum, timeout); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int fc = finished_count;
        done_at = 2;
        pulse_start();
        pulse_start();
        while (!core_req && n < 50) begin
            tick();
            n++;
        end
        tick();
        pulse_start();
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        repeat (10) tick();
        checks++; if (finished_count !== fc + 1 || busy !== 1'b0) begin
            errors++; $display("FAIL ignored_start got fin=%0d busy=%b want %0d 0", finished_count, busy, fc + 1); end
        checks++; if (cycles !== 16'd2) begin errors++; $display("FAIL b2b_cycles got %0d want 2", cycles); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_run_readback();
        test_watchdog();
        test_mid_run_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
